// File: rtl/stopwatch_ctrl_pkg.sv
// stopwatch_pkg: shared state encoding and debounce defaults for the
// stopwatch sequencing controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    SAT   = 2'd3
  } state_t;

  // 20 ms of stable input at 100 MHz before a debounced level may change.
  localparam int DB_CYCLES_DEFAULT = 2_000_000;
  localparam int DB_W_DEFAULT      = 21;

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchronizer, counting debouncer and registered
// rising-edge pulse for one raw push-button.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int DB_W      = DB_W_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic            r_level_d;
  logic            r_pulse;
  logic [DB_W-1:0] r_cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Flip the level only after DB_CYCLES consecutive differing samples; any agreeing sample restarts the count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (r_sync2 == r_level) begin
      r_cnt   <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_level <= r_sync2;
      r_cnt   <= '0;
    end else begin
      r_cnt   <= r_cnt + DB_W'(1);
    end
  end

  // One-cycle pulse on each debounced rising edge, so a held button fires once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_level_d <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_level_d <= r_level;
      r_pulse   <= r_level & ~r_level_d;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounces go/clear/direction buttons and sequences the
// stopwatch datapath (enable, clr, up) through IDLE/RUN/PAUSE/SAT.
// Optional lap/display-hold feature is built when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int DB_W      = DB_W_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_go,
  input  logic       btn_clr,
  input  logic       btn_dir,
  input  logic       btn_lap,
  input  logic       at_max,
  input  logic       at_zero,
  output logic       enable,
  output logic       clr,
  output logic       up,
  output logic       hold,
  output logic [1:0] state
);

  logic   w_go_p;
  logic   w_clr_p;
  logic   w_dir_p;
  logic   w_lap_p;
  logic   w_limit;

  state_t r_state;
  state_t w_next_state;
  logic   r_enable;
  logic   r_clr;
  logic   r_up;
  logic   w_next_up;
  logic   w_next_clr;
  logic   r_hold;
  logic   w_next_hold;

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_go (
    .clock(clock), .reset(reset), .i_btn(btn_go), .o_pulse(w_go_p)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_clr (
    .clock(clock), .reset(reset), .i_btn(btn_clr), .o_pulse(w_clr_p)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_dir (
    .clock(clock), .reset(reset), .i_btn(btn_dir), .o_pulse(w_dir_p)
  );

`ifdef STOPWATCH_LAP_EN
  btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_lap (
    .clock(clock), .reset(reset), .i_btn(btn_lap), .o_pulse(w_lap_p)
  );
`else
  logic w_unused_lap;
  assign w_unused_lap = btn_lap;
  assign w_lap_p      = 1'b0;
`endif

  // The count has reached the end it is heading towards.
  assign w_limit = (r_up & at_max) | (~r_up & at_zero);

  // Next-state and next-output decode; press pulses resolve clr > go > dir > lap.
  always_comb begin
    w_next_state = r_state;
    w_next_up    = r_up;
    w_next_clr   = 1'b0;
    w_next_hold  = r_hold;
    if (w_clr_p) begin
      w_next_state = IDLE;
      w_next_clr   = 1'b1;
      w_next_hold  = 1'b0;
    end else if (w_go_p) begin
      case (r_state)
        IDLE, PAUSE: if (!w_limit) w_next_state = RUN;
        RUN: begin
          w_next_state = PAUSE;
          w_next_hold  = 1'b0;
        end
        default: ;
      endcase
    end else if (w_limit && (r_state == RUN)) begin
      w_next_state = SAT;
      w_next_hold  = 1'b0;
    end else if (w_dir_p) begin
      case (r_state)
        IDLE, PAUSE: w_next_up = ~r_up;
        SAT: begin
          w_next_up    = ~r_up;
          w_next_state = PAUSE;
        end
        default: ;
      endcase
    end else if (w_lap_p && (r_state == RUN)) begin
      w_next_hold = ~r_hold;
    end
  end

  // State and registered datapath controls; reset drops enable at once without a clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_enable <= 1'b0;
      r_clr    <= 1'b0;
      r_up     <= 1'b1;
    end else begin
      r_state  <= w_next_state;
      r_enable <= (w_next_state == RUN);
      r_clr    <= w_next_clr;
      r_up     <= w_next_up;
    end
  end

`ifdef STOPWATCH_LAP_EN
  // Display-freeze level toggled by lap presses while running.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hold <= 1'b0;
    end else begin
      r_hold <= w_next_hold;
    end
  end
`else
  assign r_hold = 1'b0;
`endif

  assign enable = r_enable;
  assign clr    = r_clr;
  assign up     = r_up;
  assign hold   = r_hold;
  assign state  = r_state;

endmodule
